// File: rtl/conv_viterbi_codec_if.sv
// Symbol/bit strobes between the link datapath and the convolutional codec.
// The master side drives the encoder bit and received-symbol inputs.
interface conv_viterbi_codec_if;
  logic       enc_valid_in;
  logic       enc_bit_in;
  logic       enc_valid_out;
  logic [1:0] enc_sym_out;
  logic       dec_valid_in;
  logic [1:0] dec_sym_in;
  logic       dec_valid_out;
  logic       dec_bit_out;

  modport master (
    output enc_valid_in, enc_bit_in, dec_valid_in, dec_sym_in,
    input  enc_valid_out, enc_sym_out, dec_valid_out, dec_bit_out
  );
  modport slave (
    input  enc_valid_in, enc_bit_in, dec_valid_in, dec_sym_in,
    output enc_valid_out, enc_sym_out, dec_valid_out, dec_bit_out
  );
endinterface

// File: rtl/conv_viterbi_codec.sv
// Rate-1/2 convolutional encoder plus hard-decision Viterbi decoder with
// register-exchange survivors; encoder and decoder are fully independent.
module conv_viterbi_codec #(
  parameter int            K  = 3,
  parameter logic [K-1:0]  G0 = 3'b111,
  parameter logic [K-1:0]  G1 = 3'b101,
  parameter int            D  = 15,
  parameter int            MW = 8
) (
  input  logic                clk,
  input  logic                rst,
  conv_viterbi_codec_if.slave bus
);
  localparam int S  = 1 << (K-1);
  localparam int FW = $clog2(D+1);
  localparam logic [MW-1:0] PM_INIT = {2'b01, {(MW-2){1'b0}}};

  function automatic logic [1:0] code_sym(input logic b, input logic [K-2:0] m);
    logic [K-1:0] v;
    v = {b, m};
    return {^(v & G0), ^(v & G1)};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  // Encoder
  logic [K-2:0] m_q, m_d;
  logic         enc_valid_q, enc_valid_d;
  logic [1:0]   enc_sym_q, enc_sym_d;

  always_comb begin
    m_d         = m_q;
    enc_sym_d   = enc_sym_q;
    enc_valid_d = 1'b0;
    if (bus.enc_valid_in) begin
      enc_sym_d   = code_sym(bus.enc_bit_in, m_q);
      enc_valid_d = 1'b1;
      m_d         = {bus.enc_bit_in, m_q[K-2:1]};
    end
  end

  // Decoder state
  logic [MW-1:0] pm_q   [S];
  logic [MW-1:0] pm_d   [S];
  logic [MW-1:0] pm_acs [S];
  logic [MW-1:0] pm_norm[S];
  logic [D-1:0]  surv_q  [S];
  logic [D-1:0]  surv_d  [S];
  logic [D-1:0]  surv_acs[S];
  logic [S-1:0]  msb_vec;
  logic          all_msb;
  logic [FW-1:0] f_q, f_d, f_inc;
  logic          dec_valid_q, dec_valid_d;
  logic          dec_bit_q, dec_bit_d;
  logic [K-2:0]  best_idx;

  // One add-compare-select unit per next state; predecessors differ only in the LSB.
  for (genvar gi = 0; gi < S; gi++) begin : g_acs
    localparam int   P0 = (2 * gi) % S;
    localparam int   P1 = P0 + 1;
    localparam logic B  = ((gi >> (K-2)) & 1) == 1;
    logic [1:0]    bm0, bm1;
    logic [MW-1:0] cand0, cand1;
    logic          sel;
    assign bm0   = hamming(bus.dec_sym_in, code_sym(B, (K-1)'(P0)));
    assign bm1   = hamming(bus.dec_sym_in, code_sym(B, (K-1)'(P1)));
    assign cand0 = pm_q[P0] + {{(MW-2){1'b0}}, bm0};
    assign cand1 = pm_q[P1] + {{(MW-2){1'b0}}, bm1};
    assign sel   = cand1 < cand0;
    assign pm_acs[gi]   = sel ? cand1 : cand0;
    assign surv_acs[gi] = {(sel ? surv_q[P1][D-2:0] : surv_q[P0][D-2:0]), B};
    assign msb_vec[gi]  = pm_acs[gi][MW-1];
    assign pm_norm[gi]  = all_msb ? {1'b0, pm_acs[gi][MW-2:0]} : pm_acs[gi];
  end

  assign all_msb = &msb_vec;
  assign f_inc   = (f_q == FW'(D)) ? f_q : f_q + 1'b1;

  always_comb begin
    pm_d        = pm_q;
    surv_d      = surv_q;
    f_d         = f_q;
    dec_bit_d   = dec_bit_q;
    dec_valid_d = 1'b0;
    best_idx    = '0;
    for (int s = 1; s < S; s++) begin
      if (pm_norm[s] < pm_norm[best_idx]) best_idx = (K-1)'(s);
    end
    if (bus.dec_valid_in) begin
      pm_d        = pm_norm;
      surv_d      = surv_acs;
      f_d         = f_inc;
      dec_bit_d   = surv_acs[best_idx][D-1];
      dec_valid_d = (f_inc == FW'(D));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q         <= '0;
      enc_valid_q <= 1'b0;
      enc_sym_q   <= '0;
      f_q         <= '0;
      dec_valid_q <= 1'b0;
      dec_bit_q   <= 1'b0;
      for (int s = 0; s < S; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        surv_q[s] <= '0;
      end
    end else begin
      m_q         <= m_d;
      enc_valid_q <= enc_valid_d;
      enc_sym_q   <= enc_sym_d;
      f_q         <= f_d;
      dec_valid_q <= dec_valid_d;
      dec_bit_q   <= dec_bit_d;
      pm_q        <= pm_d;
      surv_q      <= surv_d;
    end
  end

  assign bus.enc_valid_out = enc_valid_q;
  assign bus.enc_sym_out   = enc_sym_q;
  assign bus.dec_valid_out = dec_valid_q;
  assign bus.dec_bit_out   = dec_bit_q;
endmodule
